// File: rtl/sfp_lane_sched_pkg.sv
// sfp_lane_sched_pkg: shared width helpers, FSM encoding and lane slice macro
`define SFP_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package sfp_lane_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, HOLD = 2'd2} state_t;

    function automatic int fix_w(int sig_w, int low_exp);
        return sig_w + 4 + low_exp;
    endfunction

    function automatic int fmt_w(int exp_w, int sig_w);
        return 1 + exp_w + sig_w;
    endfunction
endpackage

// File: rtl/sfp_lane_sched_if.sv
// sfp_lane_sched_if: block input and packed SFP output handshakes
interface sfp_lane_sched_if
    import sfp_lane_sched_pkg::*;
#(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = fmt_w(expWidth, sigWidth),
    parameter int low_expand  = 2,
    parameter int LANES       = 4
);
    localparam int FIXW = fix_w(sigWidth, low_expand);
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*FIXW-1:0]        in_fix;
    logic [expWidth-1:0]          in_max_exp;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*formatWidth-1:0] out_sfp;
    logic [LANES-1:0]             out_zero_mask;
    logic                         busy;

    modport master (
        output in_valid, in_fix, in_max_exp, out_ready,
        input  in_ready, out_valid, out_sfp, out_zero_mask, busy
    );
    modport slave (
        input  in_valid, in_fix, in_max_exp, out_ready,
        output in_ready, out_valid, out_sfp, out_zero_mask, busy
    );
endinterface

// File: rtl/sfp_lane_sched_fix2sfp.sv
// sfp_lane_sched_fix2sfp: combinational two's-complement fixed point to SFP converter
module sfp_lane_sched_fix2sfp
    import sfp_lane_sched_pkg::*;
#(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = fmt_w(expWidth, sigWidth),
    parameter int low_expand  = 2,
    localparam int FIXW       = fix_w(sigWidth, low_expand)
) (
    input  logic [FIXW-1:0]        fix,
    input  logic [expWidth-1:0]    max_exp,
    output logic [formatWidth-1:0] sfp,
    output logic                   zero
);
    logic [FIXW-1:0]     mag;
    logic [FIXW-2:0]     m;
    logic [FIXW-2:0]     norm;
    logic [expWidth-1:0] e;
    int                  pos;
    int                  ex;

    always_comb begin
        mag = fix[FIXW-1] ? ~fix + 1'b1 : fix;
        m = mag[FIXW-2:0];
        pos = 0;
        for (int k = 0; k < FIXW - 1; k++) if (m[k]) pos = k;
        norm = m << (FIXW - 2 - pos);
        // a leading one at bit sigWidth+low_expand-1 maps to exactly max_exp
        ex = int'(max_exp) + pos - (sigWidth + low_expand - 1);
        e = ex < 0 ? '0 : ex > (2 ** expWidth) - 1 ? '1 : ex[expWidth-1:0];
        zero = m == '0;
        sfp = zero ? '0 : {fix[FIXW-1], e, norm[FIXW-2 -: sigWidth]};
    end
endmodule

// File: rtl/sfp_lane_sched.sv
// sfp_lane_sched: converts a captured block of fixed-point lanes to SFP one lane per
// cycle through a single shared converter, then holds the packed vector for handoff.
module sfp_lane_sched
    import sfp_lane_sched_pkg::*;
#(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = fmt_w(expWidth, sigWidth),
    parameter int low_expand  = 2,
    parameter int LANES       = 4
) (
    input logic             clk,
    input logic             rst,
    sfp_lane_sched_if.slave bus
);
    localparam int FIXW = fix_w(sigWidth, low_expand);
    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    state_t                       state_q, state_d;
    logic [CW-1:0]                lane_q, lane_d;
    logic [LANES*FIXW-1:0]        fix_q, fix_d;
    logic [expWidth-1:0]          exp_q, exp_d;
    logic [LANES*formatWidth-1:0] sfp_q, sfp_d;
    logic [LANES-1:0]             zm_q, zm_d;
    logic [FIXW-1:0]              cv_fix;
    logic [formatWidth-1:0]       cv_sfp;
    logic                         cv_zero;

    assign cv_fix = `SFP_LANE(fix_q, lane_q, FIXW);

    sfp_lane_sched_fix2sfp #(
        .expWidth   (expWidth),
        .sigWidth   (sigWidth),
        .formatWidth(formatWidth),
        .low_expand (low_expand)
    ) u_cvt (
        .fix    (cv_fix),
        .max_exp(exp_q),
        .sfp    (cv_sfp),
        .zero   (cv_zero)
    );

    always_comb begin
        state_d = state_q;
        lane_d = lane_q;
        fix_d = fix_q;
        exp_d = exp_q;
        sfp_d = sfp_q;
        zm_d = zm_q;
        if (state_q == IDLE) begin
            if (bus.in_valid) begin
                fix_d = bus.in_fix;
                exp_d = bus.in_max_exp;
                lane_d = '0;
                state_d = CONV;
            end
        end else if (state_q == CONV) begin
            `SFP_LANE(sfp_d, lane_q, formatWidth) = cv_sfp;
            zm_d[lane_q] = cv_zero;
            lane_d = lane_q == LAST ? '0 : lane_q + 1'b1;
            state_d = lane_q == LAST ? HOLD : CONV;
        end else begin
            state_d = bus.out_ready ? IDLE : HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q <= '0;
            fix_q <= '0;
            exp_q <= '0;
            sfp_q <= '0;
            zm_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q <= lane_d;
            fix_q <= fix_d;
            exp_q <= exp_d;
            sfp_q <= sfp_d;
            zm_q <= zm_d;
        end
    end

    assign bus.in_ready = state_q == IDLE;
    assign bus.out_valid = state_q == HOLD;
    assign bus.busy = state_q != IDLE;
    assign bus.out_sfp = sfp_q;
    assign bus.out_zero_mask = zm_q;
endmodule

// File: tb/tb_sfp_lane_sched.sv
// tb_sfp_lane_sched: directed and randomized block checks for sfp_lane_sched
module tb_sfp_lane_sched;
    import sfp_lane_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    sfp_lane_sched_if #(.expWidth(4), .sigWidth(4), .formatWidth(9), .low_expand(2), .LANES(4)) bus ();
    sfp_lane_sched #(.expWidth(4), .sigWidth(4), .formatWidth(9), .low_expand(2), .LANES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ref_conv(input logic [9:0] f, input logic [3:0] e);
        int v, a, p, ex;
        logic [3:0] m;
        v = int'($signed(f));
        a = (v < 0 ? -v : v) & 'h1FF;
        if (a == 0) return 9'h000;
        p = 8;
        while (a[p] == 1'b0) p--;
        m = p >= 3 ? 4'((a >> (p - 3)) & 15) : 4'((a << (3 - p)) & 15);
        ex = int'(e) + p - 5;
        if (ex < 0) ex = 0;
        if (ex > 15) ex = 15;
        return {f[9], ex[3:0], m};
    endfunction

    function automatic logic ref_zero(input logic [9:0] f);
        int v;
        v = int'($signed(f));
        return ((v < 0 ? -v : v) & 'h1FF) == 0;
    endfunction

    task automatic gen();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            bus.in_fix[i*10 +: 10] = r[2:0] == 3'd0 ? 10'h000 : r[13:4];
        end
        bus.in_max_exp = 4'($urandom_range(0, 15));
    endtask

    // Presents one block at a negedge, scrambles the inputs after acceptance and
    // waits (bounded) for out_valid, returning the number of negedges waited.
    task automatic send_and_wait(input logic [39:0] f, input logic [3:0] e, output int lat);
        bus.in_valid = 1'b1;
        bus.in_fix = f;
        bus.in_max_exp = e;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_fix = ~f;
        bus.in_max_exp = ~e;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b want 1 0 0", bus.in_ready, bus.out_valid, bus.busy);
        end
        total++;
        if (bus.out_sfp !== 36'h0 || bus.out_zero_mask !== 4'h0) begin
            bad++;
            $display("FAIL reset_data got sfp=%h zm=%h want 0 0", bus.out_sfp, bus.out_zero_mask);
        end
    endtask

    task automatic test_basic();
        int lat;
        send_and_wait({10'h000, 10'h001, 10'h3F8, 10'h008}, 4'd5, lat);
        total++;
        if (lat !== 5) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=5", lat);
        end
        total++;
        if (bus.out_sfp !== {9'h000, 9'h008, 9'h138, 9'h038}) begin
            bad++;
            $display("FAIL basic_sfp got=%h want=%h", bus.out_sfp, {9'h000, 9'h008, 9'h138, 9'h038});
        end
        total++;
        if (bus.out_zero_mask !== 4'b1000) begin
            bad++;
            $display("FAIL basic_zm got=%b want=1000", bus.out_zero_mask);
        end
        release_out();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_release got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_clamp();
        int lat;
        send_and_wait({10'h3FF, 10'h010, 10'h002, 10'h001}, 4'd2, lat);
        total++;
        if (bus.out_sfp !== {9'h108, 9'h018, 9'h008, 9'h008} || bus.out_zero_mask !== 4'h0) begin
            bad++;
            $display("FAIL underflow got sfp=%h zm=%b want %h 0000", bus.out_sfp, bus.out_zero_mask,
                     {9'h108, 9'h018, 9'h008, 9'h008});
        end
        release_out();
        send_and_wait({10'h1FF, 10'h07F, 10'h3F0, 10'h100}, 4'd14, lat);
        total++;
        if (bus.out_sfp !== {9'h0FF, 9'h0FF, 9'h1D8, 9'h0F8} || bus.out_zero_mask !== 4'h0) begin
            bad++;
            $display("FAIL overflow got sfp=%h zm=%b want %h 0000", bus.out_sfp, bus.out_zero_mask,
                     {9'h0FF, 9'h0FF, 9'h1D8, 9'h0F8});
        end
        release_out();
    endtask

    task automatic test_hold_stall();
        int lat;
        send_and_wait({10'h000, 10'h001, 10'h3F8, 10'h008}, 4'd5, lat);
        bus.in_valid = 1'b1;
        bus.in_fix = {10'h3FF, 10'h010, 10'h002, 10'h001};
        bus.in_max_exp = 4'd2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (bus.out_sfp !== {9'h000, 9'h008, 9'h138, 9'h038} || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got sfp=%h rdy=%b vld=%b", c, bus.out_sfp, bus.in_ready, bus.out_valid);
            end
        end
        release_out();
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_idle got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_accept got busy=%b want 1", bus.busy);
        end
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 5 || bus.out_sfp !== {9'h108, 9'h018, 9'h008, 9'h008}) begin
            bad++;
            $display("FAIL stall_next got lat=%0d sfp=%h want 5 %h", lat, bus.out_sfp, {9'h108, 9'h018, 9'h008, 9'h008});
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.in_valid = 1'b1;
        bus.in_fix = {10'h1FF, 10'h07F, 10'h3F0, 10'h100};
        bus.in_max_exp = 4'd14;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL conv_busy got busy=%b rdy=%b want 1 0", bus.busy, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.out_sfp !== 36'h0 || bus.out_zero_mask !== 4'h0) begin
            bad++;
            $display("FAIL midrst got vld=%b rdy=%b busy=%b sfp=%h zm=%b", bus.out_valid, bus.in_ready,
                     bus.busy, bus.out_sfp, bus.out_zero_mask);
        end
        send_and_wait({10'h000, 10'h001, 10'h3F8, 10'h008}, 4'd5, lat);
        total++;
        if (lat !== 5 || bus.out_sfp !== {9'h000, 9'h008, 9'h138, 9'h038} || bus.out_zero_mask !== 4'b1000) begin
            bad++;
            $display("FAIL midrst_next got lat=%0d sfp=%h zm=%b", lat, bus.out_sfp, bus.out_zero_mask);
        end
        release_out();
    endtask

    task automatic test_zero();
        int lat;
        send_and_wait(40'h0, 4'd9, lat);
        total++;
        if (bus.out_sfp !== 36'h0 || bus.out_zero_mask !== 4'hF) begin
            bad++;
            $display("FAIL zero_block got sfp=%h zm=%b want 0 1111", bus.out_sfp, bus.out_zero_mask);
        end
        release_out();
        send_and_wait({10'h000, 10'h000, 10'h000, 10'h200}, 4'd7, lat);
        total++;
        if (bus.out_sfp !== 36'h0 || bus.out_zero_mask !== 4'hF) begin
            bad++;
            $display("FAIL zero_minneg got sfp=%h zm=%b want 0 1111", bus.out_sfp, bus.out_zero_mask);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [35:0] q_sfp[$];
        logic [3:0]  q_zm[$];
        logic [35:0] es;
        logic [3:0]  ez;
        int accepts = 0, outs = 0, cyc = 0, last = -1;
        bit acc;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        gen();
        while (outs < 1000 && cyc < 8000) begin
            acc = bus.in_ready && bus.in_valid;
            if (acc) begin
                for (int i = 0; i < 4; i++) begin
                    es[i*9 +: 9] = ref_conv(bus.in_fix[i*10 +: 10], bus.in_max_exp);
                    ez[i] = ref_zero(bus.in_fix[i*10 +: 10]);
                end
                q_sfp.push_back(es);
                q_zm.push_back(ez);
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 6) begin
                        bad++;
                        $display("FAIL b2b_interval got=%0d want=6", cyc - last);
                    end
                end
                last = cyc;
                accepts++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (accepts < 1000) gen();
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                total++;
                if (q_sfp.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious got out_valid with no block pending");
                end else begin
                    es = q_sfp.pop_front();
                    ez = q_zm.pop_front();
                    if (bus.out_sfp !== es || bus.out_zero_mask !== ez) begin
                        bad++;
                        $display("FAIL b2b_data blk=%0d got sfp=%h zm=%b want %h %b", outs, bus.out_sfp,
                                 bus.out_zero_mask, es, ez);
                    end
                end
                outs++;
            end
        end
        total++;
        if (outs !== 1000 || accepts !== 1000 || q_sfp.size() !== 0) begin
            bad++;
            $display("FAIL b2b_count got outs=%0d accepts=%0d pending=%0d want 1000 1000 0", outs, accepts, q_sfp.size());
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_fix = '0;
        bus.in_max_exp = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_hold_stall();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
